// File: rtl/cla_pkg.sv
// Shared types and sizes for the carry lookahead adder BIST slice.
// Holds the engine state enum and the default widths.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } bist_state_t;

  localparam int CLA_WIDTH = 4;
  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/cla_bist_if.sv
// Adder operand/result bus between the BIST engine and the adder.
// master: drives A/B/C0, reads S/Cout. slave: the adder side.
interface cla_bist_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C0;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (
    output A, B, C0,
    input  S, Cout
  );

  modport slave (
    input  A, B, C0,
    output S, Cout
  );

endinterface

// File: rtl/cla_ref_pipe.sv
// LATENCY-deep delay line for {valid, expected sum, vector}.
// Ports: clk, i_clr_n (sync active-low clear of valids), i_* in, o_* out.
module cla_ref_pipe #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic             i_valid,
  input  logic [WIDTH:0]   i_exp,
  input  logic [2*WIDTH:0] i_vec,
  output logic             o_valid,
  output logic [WIDTH:0]   o_exp,
  output logic [2*WIDTH:0] o_vec
);

  logic [LATENCY-1:0] r_valid;
  logic [WIDTH:0]     r_exp [LATENCY];
  logic [2*WIDTH:0]   r_vec [LATENCY];

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < LATENCY; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

  // Payload is only meaningful under its valid bit.
  always_ff @(posedge clk) begin
    r_exp[0] <= i_exp;
    r_vec[0] <= i_vec;
    for (int i = 1; i < LATENCY; i++) begin
      r_exp[i] <= r_exp[i-1];
      r_vec[i] <= r_vec[i-1];
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_exp   = r_exp[LATENCY-1];
  assign o_vec   = r_vec[LATENCY-1];

endmodule

// File: rtl/cla_bist.sv
// BIST engine: sweeps all {A,B,C0} into the adder and checks {Cout,S}.
// Ports: clk, reset (sync low), start, bus (adder), busy/done/pass,
// err_count (saturating), first_fail (first bad {A,B,C0}).
module cla_bist
  import cla_pkg::*;
#(
  parameter int WIDTH   = CLA_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  cla_bist_if.master           bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2*WIDTH:0]     first_fail
);

  localparam int VW = 2*WIDTH+1;
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [VW-1:0] VEC_LAST = '1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LATENCY-1);

  bist_state_t r_state;
  bist_state_t w_next;

  logic [VW-1:0]        r_vec;
  logic [DW-1:0]        r_drain;
  logic [ERR_CNT_W-1:0] r_err;
  logic [VW-1:0]        r_ff;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_c0;
  logic [WIDTH:0]   w_exp;
  logic             w_start_run;
  logic             w_clr_n;
  logic             w_pv;
  logic [WIDTH:0]   w_pexp;
  logic [VW-1:0]    w_pvec;
  logic             w_mis;

  assign w_a  = r_vec[VW-1:WIDTH+1];
  assign w_b  = r_vec[WIDTH:1];
  assign w_c0 = r_vec[0];

  // Full WIDTH+1 result so the carry is checked too.
  assign w_exp = {1'b0, w_a} + {1'b0, w_b}
               + {{WIDTH{1'b0}}, w_c0};

  assign w_start_run = start
    && (r_state == IDLE || r_state == DONE);

  // A new run flushes whatever the delay line holds.
  assign w_clr_n = reset && !w_start_run;

  cla_ref_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk     (clk),
    .i_clr_n (w_clr_n),
    .i_valid (r_state == RUN),
    .i_exp   (w_exp),
    .i_vec   (r_vec),
    .o_valid (w_pv),
    .o_exp   (w_pexp),
    .o_vec   (w_pvec)
  );

  assign w_mis = w_pv && (w_pexp != {bus.Cout, bus.S});

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == IDLE):
        if (start) w_next = RUN;
      (r_state == RUN):
        if (r_vec == VEC_LAST) w_next = DRAIN;
      (r_state == DRAIN):
        if (r_drain == DRAIN_LAST) w_next = DONE;
      (r_state == DONE):
        if (start) w_next = RUN;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_drain <= '0;
      r_err   <= '0;
      r_ff    <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_run) begin
        r_vec   <= '0;
        r_drain <= '0;
        r_err   <= '0;
        r_ff    <= '0;
      end else begin
        if (r_state == RUN && r_vec != VEC_LAST) begin
          r_vec <= r_vec + 1'b1;
        end
        if (r_state == DRAIN) begin
          r_drain <= r_drain + 1'b1;
        end
        if (w_mis) begin
          if (r_err != '1) r_err <= r_err + 1'b1;
          // Zero count means no error yet this run.
          if (r_err == '0) r_ff <= w_pvec;
        end
      end
    end
  end

  assign bus.A  = w_a;
  assign bus.B  = w_b;
  assign bus.C0 = w_c0;

  assign busy       = (r_state == RUN) || (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign pass       = done && (r_err == '0);
  assign err_count  = r_err;
  assign first_fail = r_ff;

endmodule

// File: tb/tb_cla_bist.sv
// Scoreboard bench for cla_bist: faulty/clean adders, reset, restart.
// Expected run results are queued; monitors check them on done rise.
module tb_cla_bist;
  import cla_pkg::*;

  localparam int W  = CLA_WIDTH;
  localparam int VW = 2*W+1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start0;
  logic       start1;
  logic [1:0] fault;

  cla_bist_if #(.WIDTH(W)) bus0 ();
  cla_bist_if #(.WIDTH(W)) bus1 ();

  logic          busy0, done0, pass0;
  logic          busy1, done1, pass1;
  logic [15:0]   err0, err1;
  logic [VW-1:0] ff0, ff1;

  cla_bist #(.WIDTH(W), .LATENCY(1)) u0 (
    .clk        (clk),
    .reset      (reset),
    .start      (start0),
    .bus        (bus0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_count  (err0),
    .first_fail (ff0)
  );

  cla_bist #(.WIDTH(W), .LATENCY(2)) u1 (
    .clk        (clk),
    .reset      (reset),
    .start      (start1),
    .bus        (bus1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err1),
    .first_fail (ff1)
  );

  // Registered adders; fault 1: S[0] stuck 0, fault 2: Cout stuck 0.
  logic [W:0] r_sum0, r_sum1;
  always @(posedge clk) begin
    r_sum0 <= {1'b0, bus0.A} + {1'b0, bus0.B}
            + {{W{1'b0}}, bus0.C0};
    r_sum1 <= {1'b0, bus1.A} + {1'b0, bus1.B}
            + {{W{1'b0}}, bus1.C0};
  end
  assign bus0.S    = (fault == 2'd1) ? {r_sum0[W-1:1], 1'b0}
                                     : r_sum0[W-1:0];
  assign bus0.Cout = (fault == 2'd2) ? 1'b0 : r_sum0[W];
  assign bus1.S    = r_sum1[W-1:0];
  assign bus1.Cout = r_sum1[W];

  typedef struct {
    int err;
    int ff;
    int pass;
    int lat;
    bit nz;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int s0     = 0;
  int s1     = 0;
  logic d0_q = 1'b0;
  logic d1_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(int err, int ff, int ps,
                              int lat, bit nz);
    exp_t e;
    e.err  = err;
    e.ff   = ff;
    e.pass = ps;
    e.lat  = lat;
    e.nz   = nz;
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    d0_q <= done0;
    if (done0 && !d0_q) begin
      if (q0.size() == 0) begin
        chk("u0 unexpected done", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("u0 err_count", int'(err0), e0.err);
        chk("u0 first_fail", int'(ff0), e0.ff);
        chk("u0 pass", int'(pass0), e0.pass);
        chk("u0 done latency", cyc - s0, e0.lat);
        chk("u0 busy with done", int'(busy0), 0);
      end
    end
  end

  always @(negedge clk) begin
    d1_q <= done1;
    if (done1 && !d1_q) begin
      if (q1.size() == 0) begin
        chk("u1 unexpected done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        if (e1.nz) chk("u1 err nonzero", int'(err1 != 0), 1);
        else       chk("u1 err_count", int'(err1), e1.err);
        chk("u1 pass", int'(pass1), e1.pass);
        chk("u1 done latency", cyc - s1, e1.lat);
        chk("u1 busy with done", int'(busy1), 0);
      end
    end
  end

  task automatic go0();
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    start0 = 1'b0;
  endtask

  task automatic go1();
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    s1 = cyc;
    start1 = 1'b0;
  endtask

  task automatic wait0(string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done0) break;
    end
    if (i == 2000) chk({tag, " timeout"}, 0, 1);
  endtask

  task automatic wait1(string tag);
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done1) break;
    end
    if (i == 2000) chk({tag, " timeout"}, 0, 1);
  endtask

  initial begin
    reset  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    fault  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", int'(busy0), 0);
    chk("rst done", int'(done0), 0);
    chk("rst pass", int'(pass0), 0);
    chk("rst err", int'(err0), 0);
    chk("rst ff", int'(ff0), 0);
    chk("rst vec", int'({bus0.A, bus0.B, bus0.C0}), 0);
    @(negedge clk);
    reset = 1'b1;

    q0.push_back(mk(0, 0, 1, 513, 1'b0));
    go0();
    wait0("clean");

    fault = 2'd1;
    q0.push_back(mk(256, 1, 0, 513, 1'b0));
    go0();
    wait0("s0 stuck");

    fault = 2'd2;
    q0.push_back(mk(256, 31, 0, 513, 1'b0));
    go0();
    wait0("cout stuck");

    fault = 2'd0;
    q1.push_back(mk(0, 0, 0, 514, 1'b1));
    go1();
    wait1("latency 2");

    // Reset for one edge at cycle 100 of a faulty run.
    fault = 2'd1;
    go0();
    repeat (99) @(posedge clk);
    #1;
    chk("pre-reset err nonzero", int'(err0 != 0), 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid rst busy", int'(busy0), 0);
    chk("mid rst done", int'(done0), 0);
    chk("mid rst vec", int'({bus0.A, bus0.B, bus0.C0}), 0);
    chk("mid rst err", int'(err0), 0);
    chk("mid rst ff", int'(ff0), 0);
    @(negedge clk);
    reset = 1'b1;
    fault = 2'd0;
    q0.push_back(mk(0, 0, 1, 513, 1'b0));
    go0();
    wait0("post reset");

    // start held high: run, DONE, immediate restart.
    fault = 2'd2;
    q0.push_back(mk(256, 31, 0, 513, 1'b0));
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    s0 = cyc;
    wait0("held start");
    fault = 2'd0;
    q0.push_back(mk(0, 0, 1, 513, 1'b0));
    @(posedge clk);
    #1;
    s0 = cyc;
    chk("restart busy", int'(busy0), 1);
    chk("restart done", int'(done0), 0);
    chk("restart err", int'(err0), 0);
    chk("restart ff", int'(ff0), 0);
    chk("restart vec", int'({bus0.A, bus0.B, bus0.C0}), 0);
    repeat (50) @(posedge clk);
    #1;
    chk("held start vec", int'({bus0.A, bus0.B, bus0.C0}), 50);
    chk("held start busy", int'(busy0), 1);
    @(negedge clk);
    start0 = 1'b0;
    wait0("restart run");

    @(negedge clk);
    chk("queue u0 empty", q0.size(), 0);
    chk("queue u1 empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
